// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state type,
// the default bit period and the frame data width.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

    // Clock cycles per serial bit at the board's system clock rate.
    localparam int UART_CLKS_PER_BIT_DEFAULT = 2320;

    // Data bits per frame (8N1).
    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states. BREAK holds off after a framing error until the line
    // returns high, so a line held low cannot produce repeated frames.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser that brings the asynchronous serial line into the clk
// domain. Both flops reset to 1, which is the idle level of the line, so that
// leaving reset never looks like a start bit.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d_i   in  asynchronous input
//   q_o   out synchronised output, two cycles behind d_i
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to settle
    // before anything downstream looks at the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver (LSB first). The byte is handed to the consumer with a
// level valid/ack handshake; a byte that arrives while the previous one is
// still unacknowledged is dropped and flagged with the sticky overrun bit.
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   rx        in   asynchronous serial input, idle high
//   rx_ack    in   consumer acknowledge, honoured while rx_valid is high
//   rx_data   out  last correctly framed byte
//   rx_valid  out  high while rx_data holds an unacknowledged byte
//   frame_err out  one-cycle pulse when the stop bit samples low
//   overrun   out  sticky, a byte was lost because rx_valid was still high
//   busy      out  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    input  logic                      rx_ack,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      commit;

    uart_state_e               state_q,     state_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic [IDX_W-1:0]          bit_idx_q,   bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q,     shreg_d;
    logic [UART_DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                      rx_valid_q,  rx_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q,   overrun_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Frame sequencing. The start bit is re-checked at its midpoint, and from
    // then on every data and stop bit is sampled one full bit period later, so
    // all samples land near the middle of their bit. cnt restarts at 0 on every
    // state entry; IDLE and BREAK hold it at 0 so the next state starts clean.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d            = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        shreg_d     = '0;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Consumer handshake. A commit takes priority over an acknowledge in the
    // same cycle: the ack frees the slot and the new byte lands in it at once,
    // leaving overrun as it was. Without an ack the held byte wins and the new
    // one is dropped.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (commit) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // State and output registers; reset drops any frame in progress and any
    // byte still waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule : uart_rx_byte

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver that consumes the `tx` line driven by the Task1B transmit path.
- Deserialises 8N1 frames (LSB first) into a parallel byte.
- Presents the byte with a level valid/ack handshake, the mirror of the tsent/trecieve handshake on the transmit side.
- Sits between the board RX pin (or a loopback of `tx`) and the display/echo logic.

Parameters:
- CLKS_PER_BIT, 2320, clk cycles per serial bit period; must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2, clk cycles from detected start edge to start-bit mid-sample.

Ports:
- clk  in  1  system clock (clk_raw domain), all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_ack  in  1  consumer acknowledge; sampled while rx_valid=1.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  level; high while rx_data holds an unacknowledged byte.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- overrun  out  1  sticky; a byte was lost because rx_valid was still high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0; shift register 0.
  - Synchroniser flops set to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Input synchronisation: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s. Input-to-rx_s latency is 2 cycles.
- Bit timing: one counter cnt, width ceil(log2(CLKS_PER_BIT)). It is reset to 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: cnt counts up to HALF_BIT-1.
    - At that cycle, if rx_s=0: go to DATA with cnt=0, bit_idx=0.
    - Otherwise go to IDLE (glitch rejected; no outputs change).
  - DATA: cnt counts up to CLKS_PER_BIT-1.
    - At that cycle: shreg[bit_idx] <= rx_s, cnt=0.
    - If bit_idx=7, go to STOP; else bit_idx+1.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
    - If rx_s=1, commit and go to IDLE.
    - If rx_s=0, frame_err=1 for exactly this one cycle, shreg is discarded, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Commit, when rx_valid=0, or rx_valid=1 with rx_ack=1 in the same cycle:
  - rx_data <= shreg; rx_valid <= 1 on the next edge.
  - overrun is unchanged.
- Commit when rx_valid=1 and rx_ack=0:
  - rx_data is unchanged (the old byte is kept); new byte dropped.
  - overrun <= 1.
- Handshake:
  - rx_ack=1 while rx_valid=1 clears rx_valid and overrun on the next edge, unless a commit happens in the same cycle.
  - rx_ack while rx_valid=0 is ignored.
  - rx_data stays stable while rx_valid=1.
- Total latency: rx_valid rises at (start-edge + 2 + HALF_BIT + 9*CLKS_PER_BIT) cycles, ±1.
- Reset mid-frame: everything returns to IDLE and any pending byte is lost. The first frame after release is received normally provided its start edge arrives after release.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}.
  - Default CLKS_PER_BIT constant.
  - UART_DATA_BITS=8.
- Sub-module uart_rx_sync: 2-flop synchroniser with async active-low reset to 1.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8):
- 8'h41 sent as 8N1 → rx_valid rises once; rx_data=8'h41; frame_err never pulses. Holding rx_ack=1 for 1 cycle → rx_valid=0 next cycle.
- Bytes 8'h41, 8'h42, 8'h43 back-to-back, each acked within 10 cycles → three rx_valid assertions with data 41, 42, 43; overrun stays 0.
- 8'h55 then 8'hAA with no ack → rx_data stays 8'h55 and overrun=1. A single ack then clears both rx_valid and overrun.
- 8'h41 sent with stop bit forced 0, then line held low 40 cycles → exactly one frame_err pulse, rx_valid stays 0, busy high until rx returns to 1. A following 8'h30 frame is received correctly.
- Low glitch of 3 cycles on idle rx → returns to IDLE at start mid-sample; no rx_valid, no frame_err.
- rst_n pulsed low during data bit 4 of 8'hFF → all outputs 0 immediately (async). A subsequent clean 8'h12 frame → rx_data=8'h12.
